pio_input_edge_irq: RTL and testbench



---
 rtl/pio_input_edge_irq_if.sv | 19 +
 rtl/pio_input_edge_irq.sv | 139 +++++++++++++
 tb/tb_pio_input_edge_irq.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pio_input_edge_irq_if.sv
// Avalon-MM slave bundle for the PIO input port.
// Word addressed, 32-bit data, registered reads.
interface pio_input_edge_irq_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/pio_input_edge_irq.sv
// Parallel input port: sync, optional debounce, sticky edge
// capture with write-1-to-clear and a maskable level irq.
module pio_input_edge_irq #(
  parameter int WIDTH           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 0,
  parameter int EDGE_TYPE       = 0
) (
  input  logic             clk,
  input  logic             reset,
  pio_input_edge_irq_if.slave bus,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);
  localparam logic [16:0] ARM_LAST =
    17'(SYNC_STAGES + DEBOUNCE_CYCLES);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_d [SYNC_STAGES];
  logic [WIDTH-1:0] s, d, e;
  logic [WIDTH-1:0] d_prev_q, d_prev_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [16:0]      arm_cnt_q, arm_cnt_d;
  logic             armed_q, armed_d;
  logic [31:0]      readdata_q, readdata_d;
  logic             irq_q, irq_d;
  logic             wr, wr_mask, wr_cap;
  logic [WIDTH-1:0] wdata;
  logic             unused_wd;

  assign wr        = bus.chipselect & ~bus.write_n;
  assign wr_mask   = wr & (bus.address == 2'd2);
  assign wr_cap    = wr & (bus.address == 2'd3);
  assign wdata     = bus.writedata[WIDTH-1:0];
  assign unused_wd = ^bus.writedata;
  assign s         = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d[0] = in_port;
    for (int i = 1; i < SYNC_STAGES; i++)
      sync_d[i] = sync_q[i-1];
  end

  if (DEBOUNCE_CYCLES == 0) begin : g_nodb
    assign d = s;
  end else begin : g_db
    localparam logic [15:0] DB_LAST =
      16'(DEBOUNCE_CYCLES - 1);
    logic [WIDTH-1:0] db_q, db_d;
    logic [15:0]      cnt_q [WIDTH];
    logic [15:0]      cnt_d [WIDTH];

    // d only follows s after it has differed for a full window
    always_comb begin
      db_d = db_q;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_d[i] = '0;
        if (s[i] != db_q[i]) begin
          if (cnt_q[i] == DB_LAST)
            db_d[i] = s[i];
          else
            cnt_d[i] = cnt_q[i] + 16'd1;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        db_q <= '0;
        for (int i = 0; i < WIDTH; i++)
          cnt_q[i] <= '0;
      end else begin
        db_q  <= db_d;
        cnt_q <= cnt_d;
      end
    end

    assign d = db_q;
  end

  always_comb begin
    if (EDGE_TYPE == 0)
      e = d & ~d_prev_q;
    else if (EDGE_TYPE == 1)
      e = ~d & d_prev_q;
    else
      e = d ^ d_prev_q;
  end

  always_comb begin
    d_prev_d  = d;
    arm_cnt_d = arm_cnt_q;
    armed_d   = armed_q;
    // hold off captures until the input pipeline has settled
    if (!armed_q) begin
      if (arm_cnt_q == ARM_LAST)
        armed_d = 1'b1;
      else
        arm_cnt_d = arm_cnt_q + 17'd1;
    end
    mask_d = wr_mask ? wdata : mask_q;
    cap_d  = (cap_q & ~(wr_cap ? wdata : '0))
           | (armed_q ? e : '0);
    irq_d  = |(cap_q & mask_q);
    case (bus.address)
      2'd0:    readdata_d = 32'(d);
      2'd2:    readdata_d = 32'(mask_q);
      2'd3:    readdata_d = 32'(cap_q);
      default: readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++)
        sync_q[i] <= '0;
      d_prev_q   <= '0;
      mask_q     <= '0;
      cap_q      <= '0;
      arm_cnt_q  <= '0;
      armed_q    <= 1'b0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      d_prev_q   <= d_prev_d;
      mask_q     <= mask_d;
      cap_q      <= cap_d;
      arm_cnt_q  <= arm_cnt_d;
      armed_q    <= armed_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
    end
  end

  assign bus.readdata = readdata_q;
  assign irq          = irq_q;
endmodule

// File: tb/tb_pio_input_edge_irq.sv
// Bench for pio_input_edge_irq: three configurations, directed
// scenarios plus random traffic against a reference model.
module tb_pio_input_edge_irq;
  logic        clk;
  logic        reset;
  logic [7:0]  in_a, in_b;
  logic [15:0] in_c;
  logic        irq_a, irq_b, irq_c;
  int          n_cmp, n_bad;

  pio_input_edge_irq_if ba();
  pio_input_edge_irq_if bb();
  pio_input_edge_irq_if bc();

  pio_input_edge_irq #(
    .WIDTH(8), .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(0), .EDGE_TYPE(0)
  ) dut_a (
    .clk(clk), .reset(reset), .bus(ba),
    .in_port(in_a), .irq(irq_a)
  );

  pio_input_edge_irq #(
    .WIDTH(8), .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0)
  ) dut_b (
    .clk(clk), .reset(reset), .bus(bb),
    .in_port(in_b), .irq(irq_b)
  );

  pio_input_edge_irq #(
    .WIDTH(16), .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(0), .EDGE_TYPE(2)
  ) dut_c (
    .clk(clk), .reset(reset), .bus(bc),
    .in_port(in_c), .irq(irq_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model of dut_a: input delay line as a queue,
  // arming as "edges seen since reset".
  localparam int SA    = 2;
  localparam int ARM_A = 3;
  logic [7:0]  m_pipe [$];
  logic [7:0]  m_dprev, m_cap, m_mask;
  logic [31:0] m_rd;
  logic        m_irq;
  int          m_n;

  task automatic model_step(
    input logic        rst,
    input logic [7:0]  din,
    input logic [1:0]  a,
    input logic        wr,
    input logic [31:0] wd
  );
    logic [7:0] dv, rise, clr;
    if (rst) begin
      m_pipe = {};
      for (int i = 0; i < SA; i++)
        m_pipe.push_back(8'h00);
      m_dprev = 0; m_cap = 0; m_mask = 0;
      m_rd = 0; m_irq = 0; m_n = 0;
    end else begin
      dv   = m_pipe[0];
      rise = (m_n >= ARM_A) ? (dv & ~m_dprev) : 8'h00;
      clr  = (wr && a == 2'd3) ? wd[7:0] : 8'h00;
      case (a)
        2'd0:    m_rd = {24'h0, dv};
        2'd2:    m_rd = {24'h0, m_mask};
        2'd3:    m_rd = {24'h0, m_cap};
        default: m_rd = 32'h0;
      endcase
      m_irq = |(m_cap & m_mask);
      m_cap = rise | (m_cap & ~clr);
      if (wr && a == 2'd2) m_mask = wd[7:0];
      m_dprev = dv;
      m_pipe.push_back(din);
      void'(m_pipe.pop_front());
      m_n++;
    end
  endtask

  task automatic tick();
    logic        r;
    logic [7:0]  di;
    logic [1:0]  a;
    logic        w;
    logic [31:0] wd;
    r  = reset;
    di = in_a;
    a  = ba.address;
    w  = ba.chipselect & ~ba.write_n;
    wd = ba.writedata;
    @(posedge clk);
    model_step(r, di, a, w, wd);
    #1;
  endtask

  task automatic wr_a(input logic [1:0] a, input logic [31:0] v);
    ba.address = a; ba.writedata = v;
    ba.chipselect = 1'b1; ba.write_n = 1'b0;
    tick();
    ba.chipselect = 1'b0; ba.write_n = 1'b1;
  endtask

  task automatic wr_c(input logic [1:0] a, input logic [31:0] v);
    bc.address = a; bc.writedata = v;
    bc.chipselect = 1'b1; bc.write_n = 1'b0;
    tick();
    bc.chipselect = 1'b0; bc.write_n = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_a = 8'hA5; in_b = 8'h00; in_c = 16'h0000;
    tick(); tick();
    n_cmp++;
    if (ba.readdata !== 32'h0) begin
      n_bad++;
      $display("FAIL rst_rd_a: got %h want 0", ba.readdata);
    end
    n_cmp++;
    if (irq_a !== 1'b0 || irq_b !== 1'b0 || irq_c !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_irq: got %b%b%b want 000",
               irq_a, irq_b, irq_c);
    end
    reset = 1'b0;
    ba.address = 2'd0;
    repeat (4) tick();
    n_cmp++;
    if (ba.readdata !== 32'h000000A5) begin
      n_bad++;
      $display("FAIL idle_data: got %h want 000000a5", ba.readdata);
    end
    ba.address = 2'd3;
    repeat (6) begin
      tick();
      n_cmp++;
      if (ba.readdata !== 32'h0) begin
        n_bad++;
        $display("FAIL start_cap: got %h want 0", ba.readdata);
      end
    end
  endtask

  task automatic test_rise_irq();
    in_a = 8'hA4;
    repeat (4) tick();
    n_cmp++;
    if (ba.readdata !== 32'h0) begin
      n_bad++;
      $display("FAIL fall_ignored: got %h want 0", ba.readdata);
    end
    wr_a(2'd2, 32'h01);
    ba.address = 2'd3;
    in_a = 8'hA5;
    tick(); tick(); tick();
    n_cmp++;
    if (irq_a !== 1'b0 || ba.readdata !== 32'h0) begin
      n_bad++;
      $display("FAIL rise_early: got irq %b rd %h want 0 0",
               irq_a, ba.readdata);
    end
    tick();
    n_cmp++;
    if (irq_a !== 1'b1 || ba.readdata !== 32'h1) begin
      n_bad++;
      $display("FAIL rise_cap: got irq %b rd %h want 1 1",
               irq_a, ba.readdata);
    end
    wr_a(2'd3, 32'h01);
    n_cmp++;
    if (irq_a !== 1'b1) begin
      n_bad++;
      $display("FAIL clr_hold: got %b want 1", irq_a);
    end
    tick();
    n_cmp++;
    if (irq_a !== 1'b0 || ba.readdata !== 32'h0) begin
      n_bad++;
      $display("FAIL clr_irq: got irq %b rd %h want 0 0",
               irq_a, ba.readdata);
    end
  endtask

  task automatic test_set_clear();
    in_a = 8'hAD;
    tick(); tick();
    wr_a(2'd3, 32'h08);
    tick();
    n_cmp++;
    if (ba.readdata !== 32'h08 || irq_a !== 1'b0) begin
      n_bad++;
      $display("FAIL set_wins: got rd %h irq %b want 08 0",
               ba.readdata, irq_a);
    end
    wr_a(2'd3, 32'h08);
    tick();
    n_cmp++;
    if (ba.readdata !== 32'h0) begin
      n_bad++;
      $display("FAIL set_clr_after: got %h want 0", ba.readdata);
    end
  endtask

  task automatic test_mask();
    wr_a(2'd2, 32'h0);
    in_a = 8'h8D;
    repeat (4) tick();
    in_a = 8'hAD;
    repeat (4) begin
      tick();
      n_cmp++;
      if (irq_a !== 1'b0) begin
        n_bad++;
        $display("FAIL masked_irq: got %b want 0", irq_a);
      end
    end
    ba.address = 2'd3;
    tick();
    n_cmp++;
    if (ba.readdata !== 32'h20) begin
      n_bad++;
      $display("FAIL mask_cap: got %h want 20", ba.readdata);
    end
    wr_a(2'd2, 32'h20);
    n_cmp++;
    if (irq_a !== 1'b0) begin
      n_bad++;
      $display("FAIL unmask_early: got %b want 0", irq_a);
    end
    tick();
    n_cmp++;
    if (irq_a !== 1'b1 || ba.readdata !== 32'h20) begin
      n_bad++;
      $display("FAIL unmask: got irq %b rd %h want 1 20",
               irq_a, ba.readdata);
    end
    wr_a(2'd2, 32'h0);
    n_cmp++;
    if (irq_a !== 1'b1) begin
      n_bad++;
      $display("FAIL remask_hold: got %b want 1", irq_a);
    end
    ba.address = 2'd3;
    tick();
    n_cmp++;
    if (irq_a !== 1'b0 || ba.readdata !== 32'h20) begin
      n_bad++;
      $display("FAIL remask: got irq %b rd %h want 0 20",
               irq_a, ba.readdata);
    end
  endtask

  task automatic test_debounce();
    bb.address = 2'd0;
    in_b = 8'h04;
    repeat (3) tick();
    in_b = 8'h00;
    repeat (8) begin
      tick();
      n_cmp++;
      if (bb.readdata !== 32'h0) begin
        n_bad++;
        $display("FAIL db_glitch: got %h want 0", bb.readdata);
      end
    end
    bb.address = 2'd3;
    tick();
    n_cmp++;
    if (bb.readdata !== 32'h0) begin
      n_bad++;
      $display("FAIL db_glitch_cap: got %h want 0", bb.readdata);
    end
    bb.address = 2'd0;
    in_b = 8'h04;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_cmp++;
      if (bb.readdata !== 32'h0) begin
        n_bad++;
        $display("FAIL db_wait%0d: got %h want 0", i, bb.readdata);
      end
    end
    tick();
    n_cmp++;
    if (bb.readdata !== 32'h04) begin
      n_bad++;
      $display("FAIL db_data: got %h want 04", bb.readdata);
    end
    bb.address = 2'd3;
    tick();
    n_cmp++;
    if (bb.readdata !== 32'h04) begin
      n_bad++;
      $display("FAIL db_cap: got %h want 04", bb.readdata);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(3) == 0) in_a = 8'($urandom);
      ba.address    = 2'($urandom);
      ba.chipselect = 1'($urandom_range(1));
      ba.write_n    = 1'($urandom_range(1));
      ba.writedata  = $urandom;
      tick();
      n_cmp++;
      if (ba.readdata !== m_rd || irq_a !== m_irq) begin
        n_bad++;
        $display("FAIL rand%0d: got rd %h irq %b want %h %b",
                 i, ba.readdata, irq_a, m_rd, m_irq);
      end
    end
    ba.chipselect = 1'b0;
    ba.write_n    = 1'b1;
  endtask

  task automatic test_anyedge_reset();
    in_c = 16'h8000;
    repeat (4) tick();
    wr_c(2'd3, 32'hFFFF_FFFF);
    tick();
    n_cmp++;
    if (bc.readdata !== 32'h0) begin
      n_bad++;
      $display("FAIL any_clr: got %h want 0", bc.readdata);
    end
    wr_c(2'd2, 32'hFFFF_FFFF);
    tick();
    n_cmp++;
    if (bc.readdata !== 32'h0000FFFF) begin
      n_bad++;
      $display("FAIL mask_upper: got %h want 0000ffff", bc.readdata);
    end
    bc.address = 2'd3;
    in_c = 16'h0000;
    repeat (4) tick();
    n_cmp++;
    if (bc.readdata !== 32'h00008000 || irq_c !== 1'b1) begin
      n_bad++;
      $display("FAIL any_fall: got rd %h irq %b want 8000 1",
               bc.readdata, irq_c);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp++;
    if (bc.readdata !== 32'h0 || irq_c !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_rst: got rd %h irq %b want 0 0",
               bc.readdata, irq_c);
    end
    n_cmp++;
    if (ba.readdata !== m_rd || irq_a !== m_irq) begin
      n_bad++;
      $display("FAIL mid_rst_a: got rd %h irq %b want %h %b",
               ba.readdata, irq_a, m_rd, m_irq);
    end
    repeat (5) tick();
    n_cmp++;
    if (bc.readdata !== 32'h0 || irq_c !== 1'b0) begin
      n_bad++;
      $display("FAIL post_rst: got rd %h irq %b want 0 0",
               bc.readdata, irq_c);
    end
    bc.address = 2'd2;
    tick();
    n_cmp++;
    if (bc.readdata !== 32'h0) begin
      n_bad++;
      $display("FAIL post_rst_mask: got %h want 0", bc.readdata);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    in_a = '0; in_b = '0; in_c = '0;
    ba.address = '0; ba.chipselect = 1'b0;
    ba.write_n = 1'b1; ba.writedata = '0;
    bb.address = '0; bb.chipselect = 1'b0;
    bb.write_n = 1'b1; bb.writedata = '0;
    bc.address = '0; bc.chipselect = 1'b0;
    bc.write_n = 1'b1; bc.writedata = '0;
    test_reset();
    test_rise_irq();
    test_set_clear();
    test_mask();
    test_debounce();
    test_random();
    test_anyedge_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
